// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared width constant and binary/Gray conversion helpers
package gray_pkg;

  localparam int GRAY_WIDTH = 4;

  function automatic logic [GRAY_WIDTH-1:0] bin2gray(input logic [GRAY_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the running XOR of all Gray bits from the MSB down.
  function automatic logic [GRAY_WIDTH-1:0] gray2bin(input logic [GRAY_WIDTH-1:0] gray);
    logic [GRAY_WIDTH-1:0] bin;
    bin[GRAY_WIDTH-1] = gray[GRAY_WIDTH-1];
    for (int i = GRAY_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// rtl/bin_to_gray.sv - combinational binary to Gray-code converter
module bin_to_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter_4bits.sv
// rtl/gray_counter_4bits.sv - free-running Gray counter with sync active-low reset and enable
module gray_counter_4bits
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  output logic [WIDTH-1:0] gray_out
);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;

  assign bin_next = bin + {{(WIDTH-1){1'b0}}, 1'b1};

  // Output register is loaded from the converted next count, keeping the port flop-driven.
  bin_to_gray #(
    .WIDTH(WIDTH)
  ) u_bin_to_gray (
    .bin  (bin_next),
    .gray (gray_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      bin      <= '0;
      gray_out <= '0;
    end else if (clk_en) begin
      bin      <= bin_next;
      gray_out <= gray_next;
    end
  end

endmodule

// File: tb/tb_gray_counter_4bits.sv
// tb/tb_gray_counter_4bits.sv - self-checking bench for gray_counter_4bits
module tb_gray_counter_4bits;
  import gray_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_en = 1'b0;
  logic [3:0] gray_out;

  int errors = 0;
  int checks = 0;
  int cnt = 0;
  logic [3:0] prev = 4'b0000;

  // Expected code sequence, written out directly from the counting order.
  logic [3:0] seq [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  gray_counter_4bits #(
    .WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .gray_out (gray_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e);
    rst    = r;
    clk_en = e;
    @(posedge clk);
    #1;
    if (!r) cnt = 0;
    else if (e) cnt = (cnt + 1) % 16;
    check("seq", gray_out, seq[cnt]);
    check("gray2bin", gray2bin(gray_out), cnt);
    if (r && e) check("hamming", $countones(gray_out ^ prev), 1);
    if (r && !e) check("hold", gray_out, prev);
    prev = gray_out;
  endtask

  initial begin
    // Reset with enable high: enable must be ignored, no X bits after the edge.
    step(1'b0, 1'b1);
    check("reset_no_x", $isunknown(gray_out), 0);
    check("reset_val", gray_out, 4'b0000);

    step(1'b1, 1'b1);
    check("first_inc", gray_out, 4'b0001);
    step(1'b1, 1'b1);
    check("inc2", gray_out, 4'b0011);
    step(1'b1, 1'b1);
    check("inc3", gray_out, 4'b0010);
    step(1'b1, 1'b1);
    check("inc4", gray_out, 4'b0110);
    step(1'b1, 1'b1);
    check("at_0111", gray_out, 4'b0111);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("held_0111", gray_out, 4'b0111);
    step(1'b1, 1'b1);
    check("resume_0101", gray_out, 4'b0101);

    while (cnt != 11) step(1'b1, 1'b1);
    check("at_1110", gray_out, 4'b1110);
    step(1'b0, 1'b1);
    check("reset_prio", gray_out, 4'b0000);
    step(1'b1, 1'b1);
    check("after_reset", gray_out, 4'b0001);

    step(1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
    check("at_1000", gray_out, 4'b1000);
    step(1'b1, 1'b1);
    check("wrap", gray_out, 4'b0000);

    step(1'b0, 1'b0);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b1);
    check("long_run", gray_out, 4'b1100);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
